capture_packer: RTL

CAPTURE_PACKER -- requirements
Module: capture_packer

---
 rtl/capture_packer_pkg.sv | 11 +
 rtl/capture_packer.sv | 79 +++++++
 2 files changed

// File: rtl/capture_packer_pkg.sv
// Shared definitions for the byte-to-halfword capture packer.
package capture_packer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  localparam logic [7:0] PAD_DEFAULT = 8'h00;

endpackage

// File: rtl/capture_packer.sv
// Packs a byte stream into 16-bit words (first byte low). A flush pads out a
// pending half word. The output register is a single slot with valid/ready.
module capture_packer
  import capture_packer_pkg::*;
#(
  parameter logic [7:0] PAD = PAD_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ack_o,
  input  logic        flush_i,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        half_o,
  output logic        flush_pend_o,
  output logic [15:0] word_cnt_o
);

  state_e     state;
  logic [7:0] low;
  logic       slot_free;
  logic       handshake;

  assign slot_free = !out_valid_o || out_ready_i;
  assign handshake = out_valid_o && out_ready_i;
  assign half_o    = (state == ST_HALF);

  // In EMPTY the byte only goes to the low register, so no free slot is needed.
  assign in_ack_o  = reset_n_i && in_valid_i && (state == ST_EMPTY || slot_free);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state        <= ST_EMPTY;
      low          <= 8'h00;
      out_data_o   <= 16'h0000;
      out_valid_o  <= 1'b0;
      flush_pend_o <= 1'b0;
      word_cnt_o   <= 16'h0000;
    end else begin
      if (handshake) begin
        word_cnt_o <= word_cnt_o + 16'd1;
      end

      // A drained slot goes empty unless a new word is loaded below.
      if (handshake) begin
        out_valid_o <= 1'b0;
      end

      case (state)
        ST_EMPTY: begin
          if (in_ack_o) begin
            low   <= in_data_i;
            state <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_ack_o) begin
            out_data_o   <= {in_data_i, low};
            out_valid_o  <= 1'b1;
            flush_pend_o <= 1'b0;
            state        <= ST_EMPTY;
          end else if ((flush_i || flush_pend_o) && slot_free) begin
            out_data_o   <= {PAD, low};
            out_valid_o  <= 1'b1;
            flush_pend_o <= 1'b0;
            state        <= ST_EMPTY;
          end else if (flush_i) begin
            flush_pend_o <= 1'b1;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule
